// File: rtl/jh_vpp_pkg.sv
// Shared types for the Vpp monitor: FSM state encoding and accumulator sizing.
package jh_vpp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_UPDATE,
        ST_COMPARE,
        ST_REPORT
    } state_e;

    // A 16-bit sample summed over 2^avg_log2 entries needs avg_log2 extra bits.
    function automatic int sum_width(input int avg_log2);
        return 16 + avg_log2;
    endfunction

endpackage

// File: rtl/jh_vpp_ringbuf.sv
// Moving-average history: 2^AVG_LOG2 x 16 register ring, read and write share wr_ptr.
module jh_vpp_ringbuf
    import jh_vpp_pkg::*;
#(
    parameter int AVG_LOG2 = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                we,
    input  logic [AVG_LOG2-1:0] wr_ptr,
    input  logic [15:0]         wr_data,
    output logic [15:0]         rd_data
);

    localparam int DEPTH = 1 << AVG_LOG2;

    logic [DEPTH-1:0][15:0] mem_q, mem_d;

    always_comb begin
        mem_d = mem_q;
        if (clr) begin
            mem_d = '0;
        end else if (we) begin
            mem_d[wr_ptr] = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) mem_q <= '0;
        else     mem_q <= mem_d;
    end

    // The slot about to be overwritten holds the oldest sample in the window.
    assign rd_data = mem_q[wr_ptr];

endmodule

// File: rtl/jh_vpp_monitor.sv
// Vpp statistics monitor: moving average, limit flags, staleness and report handshake.
// Optional peak hold is enabled by defining JH_VPP_PEAK_HOLD_EN.
module jh_vpp_monitor
    import jh_vpp_pkg::*;
#(
    parameter int          AVG_LOG2    = 3,
    parameter logic [15:0] HI_LIMIT    = 16'd12000,
    parameter logic [15:0] LO_LIMIT    = 16'd200,
    parameter logic [23:0] TIMEOUT_CYC = 24'd6500000
) (
    input  logic        CLOCK_65,
    input  logic        rst,
    input  logic        rfsig_state,
    input  logic [15:0] Vpp,
    input  logic        clear_stats,
    output logic [15:0] avg_vpp,
    output logic        avg_valid,
    output logic        over_limit,
    output logic        under_limit,
    output logic [15:0] peak_vpp,
    output logic [15:0] sample_count,
    output logic        stale,
    output logic        overrun,
    output logic        rpt_valid,
    input  logic        rpt_ready,
    output logic [15:0] rpt_data
);

    localparam int SUM_W = sum_width(AVG_LOG2);
    localparam int FW    = AVG_LOG2 + 1;
    localparam logic [AVG_LOG2:0] FILL_FULL = FW'(1 << AVG_LOG2);

    state_e              state_q, state_d;
    logic                rs_d_q, rs_d_d;
    logic                pending_q, pending_d;
    logic [15:0]         pend_v_q, pend_v_d;
    logic                cap_pend_q, cap_pend_d;
    logic [15:0]         new_v_q, new_v_d;
    logic [15:0]         old_v_q, old_v_d;
    logic [SUM_W-1:0]    sum_q, sum_d;
    logic [AVG_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [AVG_LOG2:0]   fill_q, fill_d;
    logic [15:0]         count_q, count_d;
    logic [15:0]         avg_q, avg_d;
    logic                avg_valid_q, avg_valid_d;
    logic                over_q, over_d;
    logic                under_q, under_d;
    logic [23:0]         tmo_q, tmo_d;
    logic                overrun_q, overrun_d;
    logic                rise, ring_we, ring_clr;
    logic [15:0]         ring_rd;
`ifdef JH_VPP_PEAK_HOLD_EN
    logic [15:0]         peak_q, peak_d;
`endif

    assign rise = rfsig_state & ~rs_d_q;

    jh_vpp_ringbuf #(.AVG_LOG2(AVG_LOG2)) u_ring (
        .clk     (CLOCK_65),
        .rst     (rst),
        .clr     (ring_clr),
        .we      (ring_we),
        .wr_ptr  (wr_ptr_q),
        .wr_data (new_v_q),
        .rd_data (ring_rd)
    );

    always_comb begin
        state_d     = state_q;
        rs_d_d      = rfsig_state;
        pending_d   = pending_q;
        pend_v_d    = pend_v_q;
        cap_pend_d  = cap_pend_q;
        new_v_d     = new_v_q;
        old_v_d     = old_v_q;
        sum_d       = sum_q;
        wr_ptr_d    = wr_ptr_q;
        fill_d      = fill_q;
        count_d     = count_q;
        avg_d       = avg_q;
        avg_valid_d = avg_valid_q;
        over_d      = over_q;
        under_d     = under_q;
        overrun_d   = overrun_q;
        tmo_d       = (tmo_q == TIMEOUT_CYC) ? tmo_q : tmo_q + 24'd1;
        ring_we     = 1'b0;
        ring_clr    = 1'b0;
`ifdef JH_VPP_PEAK_HOLD_EN
        peak_d      = peak_q;
`endif
        if (clear_stats) begin
            state_d     = ST_IDLE;
            pending_d   = 1'b0;
            cap_pend_d  = 1'b0;
            sum_d       = '0;
            wr_ptr_d    = '0;
            fill_d      = '0;
            count_d     = '0;
            avg_d       = '0;
            avg_valid_d = 1'b0;
            over_d      = 1'b0;
            under_d     = 1'b0;
            overrun_d   = 1'b0;
            tmo_d       = '0;
            ring_clr    = 1'b1;
`ifdef JH_VPP_PEAK_HOLD_EN
            peak_d      = '0;
`endif
        end else begin
            // Busy: park one sample, drop anything beyond that.
            if (rise && state_q != ST_IDLE) begin
                if (!pending_q) begin
                    pend_v_d  = Vpp;
                    pending_d = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
            end
            case (state_q)
                ST_IDLE: begin
                    if (pending_q) begin
                        new_v_d    = pend_v_q;
                        cap_pend_d = 1'b1;
                        pending_d  = 1'b0;
                        state_d    = ST_CAPTURE;
                        if (rise) begin
                            pend_v_d  = Vpp;
                            pending_d = 1'b1;
                        end
                    end else if (rise) begin
                        cap_pend_d = 1'b0;
                        state_d    = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (!cap_pend_q) new_v_d = Vpp;
                    old_v_d = ring_rd;
                    state_d = ST_UPDATE;
                end
                ST_UPDATE: begin
                    sum_d    = sum_q - SUM_W'(old_v_q) + SUM_W'(new_v_q);
                    ring_we  = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (fill_q != FILL_FULL) fill_d = fill_q + 1'b1;
                    if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
                    tmo_d    = '0;
`ifdef JH_VPP_PEAK_HOLD_EN
                    if (new_v_q > peak_q) peak_d = new_v_q;
`endif
                    state_d  = ST_COMPARE;
                end
                ST_COMPARE: begin
                    avg_d       = sum_q[AVG_LOG2 +: 16];
                    avg_valid_d = (fill_q == FILL_FULL);
                    over_d      = avg_valid_d && (avg_d > HI_LIMIT);
                    under_d     = avg_valid_d && (avg_d < LO_LIMIT);
                    state_d     = ST_REPORT;
                end
                ST_REPORT: begin
                    if (rpt_ready) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_65) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rs_d_q      <= 1'b0;
            pending_q   <= 1'b0;
            pend_v_q    <= '0;
            cap_pend_q  <= 1'b0;
            new_v_q     <= '0;
            old_v_q     <= '0;
            sum_q       <= '0;
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            count_q     <= '0;
            avg_q       <= '0;
            avg_valid_q <= 1'b0;
            over_q      <= 1'b0;
            under_q     <= 1'b0;
            tmo_q       <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rs_d_q      <= rs_d_d;
            pending_q   <= pending_d;
            pend_v_q    <= pend_v_d;
            cap_pend_q  <= cap_pend_d;
            new_v_q     <= new_v_d;
            old_v_q     <= old_v_d;
            sum_q       <= sum_d;
            wr_ptr_q    <= wr_ptr_d;
            fill_q      <= fill_d;
            count_q     <= count_d;
            avg_q       <= avg_d;
            avg_valid_q <= avg_valid_d;
            over_q      <= over_d;
            under_q     <= under_d;
            tmo_q       <= tmo_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef JH_VPP_PEAK_HOLD_EN
    always_ff @(posedge CLOCK_65) begin
        if (rst) peak_q <= '0;
        else     peak_q <= peak_d;
    end
    assign peak_vpp = peak_q;
`else
    assign peak_vpp = '0;
`endif

    assign avg_vpp      = avg_q;
    assign avg_valid    = avg_valid_q;
    assign over_limit   = over_q;
    assign under_limit  = under_q;
    assign sample_count = count_q;
    assign stale        = (tmo_q == TIMEOUT_CYC);
    assign overrun      = overrun_q;
    assign rpt_valid    = (state_q == ST_REPORT);
    assign rpt_data     = avg_q;

endmodule

// File: doc/jh_vpp_monitor.md
# jh_vpp_monitor

Downstream consumer of the RF-signal capture stage. Each time the capture stage raises its done level (`rfsig_state`), this block latches the 16-bit peak-to-peak measurement (`Vpp`) and keeps a 2^AVG_LOG2-sample moving average, a peak hold, a sample count and limit flags. It also offers the new average to the host/report path over a valid/ready handshake. It runs in the ADC clock domain, next to the capture stage.

## Interface
- AVG_LOG2, 3, log2 of averaging window depth (1..6)
- HI_LIMIT, 16'd12000, over-limit threshold on average
- LO_LIMIT, 16'd200, under-limit threshold on average
- TIMEOUT_CYC, 24'd6500000, cycles without a new sample before `stale` (100 ms at 65 MHz)
- CLOCK_65  in  1  single clock, all logic on posedge
- rst  in  1  reset, synchronous, active-high
- rfsig_state  in  1  capture-done level; rising edge = new `Vpp` available
- Vpp  in  16  peak-to-peak value, stable while `rfsig_state` high
- clear_stats  in  1  one-cycle pulse, clears all history
- avg_vpp  out  16  current window average
- avg_valid  out  1  window fully filled since reset/clear
- over_limit, under_limit  out  1 each  limit flags
- peak_vpp  out  16  max `Vpp` since reset/clear
- sample_count  out  16  accepted samples, saturates at 16'hFFFF
- stale  out  1  no sample within TIMEOUT_CYC
- overrun  out  1  sticky: a sample was dropped
- rpt_valid  out  1 / rpt_ready  in  1 / rpt_data  out  16  report handshake carrying `avg_vpp`

## Operation
- Edge detect: `rfsig_state` registered to `rs_d`; `edge = rfsig_state & ~rs_d`.
- FSM states:
  - IDLE: on `edge` or `pending`, go to CAPTURE.
  - CAPTURE: latch `Vpp` (or the pending value) to `new_v`; read the oldest ring entry into `old_v`.
  - UPDATE: `sum <= sum - old_v + new_v`; write `new_v` at `wr_ptr`; `wr_ptr` increments and wraps mod 2^AVG_LOG2; `fill` increments, saturating at 2^AVG_LOG2; `sample_count` increments, saturating.
  - COMPARE: `avg_vpp <= sum >> AVG_LOG2`; set `avg_valid` when `fill` is full. When `avg_valid`, `over_limit = avg > HI_LIMIT` and `under_limit = avg < LO_LIMIT`; otherwise both are 0.
  - REPORT: `rpt_valid = 1`, `rpt_data = avg_vpp`; on `rpt_valid & rpt_ready`, go to IDLE.
- Width rules:
  - `sum` is 16+AVG_LOG2 bits, unsigned, and never over/underflows.
  - Ring buffer entries are 0 after reset/clear, so the partial-window average includes zeros.
- Edge arriving outside IDLE:
  - If `pending` is clear: store `Vpp` in `pend_v` and set `pending`.
  - If `pending` is already set: drop the sample and set `overrun`.
- Stale: `tmo` counter clears on every UPDATE, otherwise increments and saturates at TIMEOUT_CYC. `stale = (tmo == TIMEOUT_CYC)`.
- clear_stats has highest priority, below `rst`:
  - Go to IDLE; `rpt_valid` drops even mid-handshake (permitted).
  - Zero `sum`, ring, `wr_ptr`, `fill`, `peak_vpp`, `sample_count`, `avg_vpp`, `avg_valid`, limit flags, `pending`, `overrun`, `tmo`.
- If `clear_stats` and `edge` occur in the same cycle, the edge is discarded.

## Timing
- Reset values: every output is 0; state is IDLE; `rs_d = 0`. A `rfsig_state` already high at reset release therefore produces an edge.
- Latency: edge seen at posedge N → CAPTURE N+1, UPDATE N+2, COMPARE N+3. `avg_vpp`, flags and `rpt_valid` are updated/asserted after posedge N+4.
- A pending sample restarts at CAPTURE on the cycle after the handshake completes.
- `rpt_data` is held constant while `rpt_valid & ~rpt_ready`.
- Minimum spacing between accepted samples with `rpt_ready` tied high: 5 cycles. The upstream capture cycle is far longer than this.

## Configuration
- `JH_VPP_PEAK_HOLD_EN` defined: in UPDATE, `peak_vpp <= max(peak_vpp, new_v)`.
- Undefined: no peak register; `peak_vpp` is tied 0.

## Structure
- Package `jh_vpp_pkg`: FSM state enum (IDLE, CAPTURE, UPDATE, COMPARE, REPORT) and a sum-width constant function of AVG_LOG2.
- One sub-module `jh_vpp_ringbuf`: 2^AVG_LOG2 × 16 register array with synchronous clear, write port, combinational read at `wr_ptr`.

## Test plan
- AVG_LOG2=2; edges with Vpp 100, 200, 300, 400 → after the 4th: `avg_vpp`=250, `avg_valid`=1; 5th edge with 500 → `avg_vpp`=350, `peak_vpp`=500 (with macro).
- HI_LIMIT=1000; four samples of 2000 → `over_limit`=1; then four samples of 500 → `over_limit`=0, `under_limit`=0.
- `rpt_ready` held low; two further edges → first becomes pending, second is dropped, `overrun`=1; release ready → pending sample reported in the next report.
- TIMEOUT_CYC=100, no edges → `stale`=1 at the 100th cycle after reset; one edge → `stale`=0 after UPDATE.
- `clear_stats` pulsed during REPORT → `rpt_valid`=0 next cycle, all statistics 0, `sample_count`=0.
- `rst` asserted in UPDATE → all outputs 0 next cycle; the next edge is processed from an empty window.
